// File: rtl/keypad_scanner_pkg.sv
// Shared constants and types for the 4x4 keypad scanner.
package keypad_scanner_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam int KEY_NUM  = KEY_ROWS * KEY_COLS;

    typedef enum logic [1:0] {
        KP_IDLE = 2'd0,
        KP_HELD = 2'd1,
        KP_LOCK = 2'd2
    } kp_state_e;

endpackage

// File: rtl/keypad_scanner_if.sv
// Key matrix pins plus the key event outputs seen by the mode state machine.
interface keypad_if;

    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_release;
    logic       key_held;

    modport master (
        output row,
        output key_code,
        output key_valid,
        output key_release,
        output key_held,
        input  col
    );

    modport slave (
        input  row,
        input  key_code,
        input  key_valid,
        input  key_release,
        input  key_held,
        output col
    );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; resets to all zeros.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // metastability stage followed by the stable output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: row drive, debounced key map and single-key press/release events.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.master kp
);

    localparam int                CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]        STAB_MAX = 4'(DEBOUNCE_SCANS);

    logic [3:0]         col_sync_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               tick_s;
    logic [1:0]         ridx_r;
    logic [3:0]         row_r;
    logic [KEY_NUM-1:0] snap_r;
    logic [KEY_NUM-1:0] snap_full_s;
    logic [KEY_NUM-1:0] prev_snap_r;
    logic [3:0]         stab_r;
    logic [3:0]         stab_next_s;
    logic [KEY_NUM-1:0] deb_r;
    logic               upd_r;
    logic [4:0]         deb_pop_s;
    kp_state_e          state_r;
    kp_state_e          state_next_s;
    logic               valid_s;
    logic               release_s;
    logic [3:0]         code_next_s;
    logic [3:0]         key_code_r;
    logic               key_valid_r;
    logic               key_release_r;
    logic               key_held_r;

    function automatic logic [4:0] popcount16(input logic [KEY_NUM-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < KEY_NUM; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [3:0] onehot_index(input logic [KEY_NUM-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // inverted columns go in so a pressed key reads as 1 after synchronization
    sync_2ff #(.WIDTH(4)) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (~kp.col),
        .q     (col_sync_s)
    );

    assign tick_s = (cnt_r == CNT_LAST);

    // row-period prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // columns are captured in the last cycle of each row period, then the next row is driven
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ridx_r <= 2'd0;
            row_r  <= 4'b1110;
            snap_r <= '0;
        end else if (tick_s) begin
            snap_r[{ridx_r, 2'b00} +: 4] <= col_sync_s;
            ridx_r <= ridx_r + 2'd1;
            row_r  <= ~(4'b0001 << (ridx_r + 2'd1));
        end else begin
            ridx_r <= ridx_r;
            row_r  <= row_r;
            snap_r <= snap_r;
        end
    end

    // full-scan view including the row-3 columns being captured this cycle
    always_comb begin
        snap_full_s         = snap_r;
        snap_full_s[15:12]  = col_sync_s;
        if (snap_full_s == prev_snap_r) begin
            if (stab_r >= STAB_MAX) begin
                stab_next_s = STAB_MAX;
            end else begin
                stab_next_s = stab_r + 4'd1;
            end
        end else begin
            stab_next_s = 4'd1;
        end
    end

    // debounce: the map is accepted once enough identical full scans have been seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_snap_r <= '0;
            stab_r      <= 4'd0;
            deb_r       <= '0;
            upd_r       <= 1'b0;
        end else if (tick_s && (ridx_r == 2'd3)) begin
            prev_snap_r <= snap_full_s;
            stab_r      <= stab_next_s;
            if (stab_next_s == STAB_MAX) begin
                deb_r <= snap_full_s;
                upd_r <= 1'b1;
            end else begin
                deb_r <= deb_r;
                upd_r <= 1'b0;
            end
        end else begin
            upd_r <= 1'b0;
        end
    end

    assign deb_pop_s = popcount16(deb_r);

    // event FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= KP_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // event FSM transitions, taken only when a fresh debounced map arrives
    always_comb begin
        state_next_s = state_r;
        if (upd_r) begin
            case (state_r)
                KP_IDLE: begin
                    if (deb_pop_s == 5'd1) begin
                        state_next_s = KP_HELD;
                    end else if (deb_pop_s >= 5'd2) begin
                        state_next_s = KP_LOCK;
                    end else begin
                        state_next_s = KP_IDLE;
                    end
                end
                KP_HELD: begin
                    if (deb_r == '0) begin
                        state_next_s = KP_IDLE;
                    end else if (deb_r != (16'd1 << key_code_r)) begin
                        state_next_s = KP_LOCK;
                    end else begin
                        state_next_s = KP_HELD;
                    end
                end
                KP_LOCK: begin
                    if (deb_r == '0) begin
                        state_next_s = KP_IDLE;
                    end else begin
                        state_next_s = KP_LOCK;
                    end
                end
                default: state_next_s = KP_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // event FSM outputs; a changed or added key ends the held key with a release
    always_comb begin
        valid_s     = 1'b0;
        release_s   = 1'b0;
        code_next_s = key_code_r;
        if (upd_r) begin
            case (state_r)
                KP_IDLE: begin
                    if (deb_pop_s == 5'd1) begin
                        valid_s     = 1'b1;
                        code_next_s = onehot_index(deb_r);
                    end else begin
                        valid_s     = 1'b0;
                    end
                end
                KP_HELD: begin
                    if ((deb_r == '0) || (deb_r != (16'd1 << key_code_r))) begin
                        release_s = 1'b1;
                    end else begin
                        release_s = 1'b0;
                    end
                end
                KP_LOCK: begin
                    release_s = 1'b0;
                end
                default: begin
                    release_s = 1'b0;
                end
            endcase
        end else begin
            valid_s = 1'b0;
        end
    end

    // registered event outputs, aligned with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code_r    <= 4'd0;
            key_valid_r   <= 1'b0;
            key_release_r <= 1'b0;
            key_held_r    <= 1'b0;
        end else begin
            key_code_r    <= code_next_s;
            key_valid_r   <= valid_s;
            key_release_r <= release_s;
            key_held_r    <= (state_next_s == KP_HELD);
        end
    end

    assign kp.row         = row_r;
    assign kp.key_code    = key_code_r;
    assign kp.key_valid   = key_valid_r;
    assign kp.key_release = key_release_r;
    assign kp.key_held    = key_held_r;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the board's 4×4 key matrix and turns raw row and column levels into clean key events for the top-level mode state machine. It is the input side of the board's display and keys pair. It drives one matrix row low at a time, samples the pulled-up column inputs, debounces the complete 16-key map and reports single-key presses and releases as one-cycle pulses with a 4-bit key code.

## Interface
Parameters:
- SCAN_DIV, default 50_000: clk cycles per row. At 50 MHz this is 1 ms per row and 4 ms per full scan. Minimum 4.
- DEBOUNCE_SCANS, default 5: consecutive identical full-scan snapshots required before the debounced map updates. Range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- row  out  4  matrix row drive, active-low, one-cold
- col  in  4  matrix column sense, active-low (pressed = 0), asynchronous to clk
- key_code  out  4  code of the last reported key, row*4 + col
- key_valid  out  1  one-cycle pulse: new single-key press, key_code valid in the same cycle
- key_release  out  1  one-cycle pulse: a previously reported key has been released
- key_held  out  1  level: a reported key is currently held

## Operation
Column synchronizer:
- 2-flop synchronizer on col. The synchronized value is inverted, so 1 = pressed.

Prescaler and row scan:
- cnt counts 0..SCAN_DIV-1 and wraps.
- tick = (cnt == SCAN_DIV-1).
- On tick: store the synchronized columns into snap[ridx*4 +: 4], then advance ridx = ridx+1 mod 4.
- row = ~(4'b0001 << ridx).

Snapshot compare (when tick is asserted and ridx == 3):
- The full snapshot snap_full is complete; it includes the row-3 columns sampled in that same cycle.
- snap_full == prev_snap: stab increments, saturating at DEBOUNCE_SCANS.
- Otherwise: stab = 1.
- prev_snap ← snap_full in both cases.
- When stab reaches DEBOUNCE_SCANS (this update or already saturated): deb ← snap_full and upd pulses for one cycle.

Event FSM (evaluated only on upd):
- IDLE:
  - popcount(deb) == 1 → HELD. key_code ← index of the set bit, key_valid = 1.
  - popcount(deb) ≥ 2 → LOCK. No event.
  - deb == 0 → stay.
- HELD:
  - deb == 0 → IDLE, key_release = 1.
  - deb ≠ 0 and deb ≠ (1 << key_code) → LOCK with key_release = 1. This covers a second key added or the key changed.
  - Otherwise stay.
- LOCK:
  - deb == 0 → IDLE. No event.
  - Any other value → stay. No event is reported until all keys are released.

Outputs:
- key_held = (state == HELD).
- key_code holds its value after release.

Reset:
- cnt = 0, ridx = 0, row = 4'b1110.
- snap = 0, prev_snap = 0, stab = 0, deb = 0.
- state = IDLE, key_code = 0, key_valid = 0, key_release = 0, key_held = 0.
- Synchronizer flops reset to 0 in the inverted (released) sense.
- Reset asserted mid-scan or mid-press aborts everything with no pulse. A key still held after reset is then reported after the normal debounce.

## Timing
- A row is driven for SCAN_DIV cycles. Columns are sampled in the last cycle of each row period, giving about SCAN_DIV-3 cycles of settle time after synchronization.
- Press latency, from the first scan whose snapshot contains the key: (DEBOUNCE_SCANS-1) further scans, plus 1 cycle from upd to the registered key_valid.
  - Worst case from a clean edge on col: (DEBOUNCE_SCANS+1) × 4 × SCAN_DIV + 4 cycles.
- Release latency: same bound.
- key_valid and key_release are registered and never both high in the same cycle. Events are at least 4×SCAN_DIV cycles apart.
- Bounce shorter than (DEBOUNCE_SCANS-1) full scans produces no event.

## Structure
- Shared header system_para.v (extended) holds:
  - KEY_ROWS = 4, KEY_COLS = 4
  - FSM encodings KP_IDLE = 2'd0, KP_HELD = 2'd1, KP_LOCK = 2'd2
- Sub-module sync_2ff (parameter WIDTH, reset value 0). It is reused for any other asynchronous board input.
- Popcount and one-hot index are local combinational functions.

## Test plan
Bench uses SCAN_DIV = 4, DEBOUNCE_SCANS = 3. The matrix model pulls col[c] low while row[r] == 0 and key (r,c) is pressed.
- Press key (2,1) clean → exactly one key_valid, key_code = 9, key_held = 1. Release → one key_release 3–4 scans later and key_held = 0.
- Press (0,0) for 1 scan only, then release → no key_valid, no key_release.
- Press (1,3) and (3,0) together → no key_valid. Release both → no pulses. Then press (3,3) → key_valid with code 15.
- Hold (0,2) until valid (code 2), then add (1,1) → key_release, state LOCK. Release (1,1) only → no event. Release all → no event.
- Toggle (3,2) every 2 scan periods for 20 scans (simulated bounce), then hold → exactly one key_valid, code 14.
- Assert rst_n low while (2,2) is held in HELD → outputs at reset values, row = 4'b1110. Deassert with the key still held → key_valid with code 10 after the debounce latency.
